// File: rtl/uart_pkg.sv
// Shared definitions for the word-assembling UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Bit periods shorter than this leave no room for the three-sample vote.
  localparam int unsigned MIN_BPS_CNT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_t;

  // Ceiling log2, never less than 1 so it can size a register directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // System clocks per serial bit.
  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Synchronises the RX pin, detects start edges and majority-votes each bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned BPS_CNT = 5208
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic uart_rxd,
  input  logic i_idle,
  output logic o_start_edge,
  output logic o_bit_val,
  output logic o_bit_strobe,
  output logic o_rxd_sync
);

  localparam int unsigned CntW = clog2(BPS_CNT);
  localparam int unsigned Mid  = BPS_CNT / 2;

  logic            r_meta;
  logic            r_sync;
  logic            r_prev;
  logic [CntW-1:0] r_cnt;
  logic            r_smp0;
  logic            r_smp1;

  // Two-flop synchroniser plus one delay stage for edge detection; idle-high on reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= uart_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // Bit-phase counter: parked at 0 while idle so a frame starts in phase with its edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (i_idle || (r_cnt == CntW'(BPS_CNT - 1))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_smp0 <= 1'b1;
      r_smp1 <= 1'b1;
    end else begin
      if (r_cnt == CntW'(Mid - 1)) r_smp0 <= r_sync;
      if (r_cnt == CntW'(Mid))     r_smp1 <= r_sync;
    end
  end

  assign o_start_edge = i_idle & r_prev & ~r_sync;
  assign o_bit_strobe = ~i_idle & (r_cnt == CntW'(Mid + 1));
  assign o_bit_val    = (r_smp0 & r_smp1) | (r_smp0 & r_sync) | (r_smp1 & r_sync);
  assign o_rxd_sync   = r_sync;

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver that packs BYTES_PER_WORD characters into one handshaked word.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned UART_BPS       = 9600,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_MODE    = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned TIMEOUT_BITS   = 16
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                uart_rxd,
  output logic [DATA_BITS*BYTES_PER_WORD-1:0] word_data,
  output logic                                word_valid,
  input  logic                                word_ready,
  output logic                                rx_busy,
  output logic                                frame_err,
  output logic                                parity_err,
  output logic                                overrun,
  output logic                                timeout_err
);

  localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned WW      = DATA_BITS * BYTES_PER_WORD;
  localparam int unsigned CntW    = clog2(BPS_CNT);
  localparam int unsigned TmoW    = clog2(TIMEOUT_BITS + 1);

  logic w_start_edge, w_bit_val, w_bit_strobe, w_rxd_sync;
  logic w_par_exp, w_frm, w_par;

  rx_state_t            r_state, w_state;
  logic [3:0]           r_bit_idx, w_bit_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_par_bit, w_par_bit;
  logic                 r_stop_bad, w_stop_bad;
  logic [2:0]           r_byte_idx, w_byte_idx;
  logic [WW-1:0]        r_asm, w_asm;
  logic [WW-1:0]        r_word, w_word;
  logic                 r_valid, w_valid;
  logic [CntW-1:0]      r_idle_cyc, w_idle_cyc;
  logic [TmoW-1:0]      r_tmo_bits, w_tmo_bits;
  logic                 r_frame_err, w_frame_err;
  logic                 r_parity_err, w_parity_err;
  logic                 r_overrun, w_overrun;
  logic                 r_timeout, w_timeout;

  uart_rx_sampler #(
    .BPS_CNT (BPS_CNT)
  ) u_sampler (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_rxd     (uart_rxd),
    .i_idle       (r_state == StIdle),
    .o_start_edge (w_start_edge),
    .o_bit_val    (w_bit_val),
    .o_bit_strobe (w_bit_strobe),
    .o_rxd_sync   (w_rxd_sync)
  );

  assign w_par_exp = (^r_shift) ^ (PARITY_MODE == PAR_ODD);

  // Frame sequencing, word assembly, handshake and idle timeout.
  always_comb begin
    w_state      = r_state;
    w_bit_idx    = r_bit_idx;
    w_shift      = r_shift;
    w_par_bit    = r_par_bit;
    w_stop_bad   = r_stop_bad;
    w_byte_idx   = r_byte_idx;
    w_asm        = r_asm;
    w_word       = r_word;
    w_valid      = r_valid;
    w_idle_cyc   = r_idle_cyc;
    w_tmo_bits   = r_tmo_bits;
    w_frame_err  = 1'b0;
    w_parity_err = 1'b0;
    w_overrun    = 1'b0;
    w_timeout    = 1'b0;
    w_frm        = 1'b0;
    w_par        = 1'b0;

    if (r_valid && word_ready) w_valid = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_state    = StStart;
          w_idle_cyc = '0;
          w_tmo_bits = '0;
        end else if (r_byte_idx != 3'd0) begin
          if (r_idle_cyc == CntW'(BPS_CNT - 1)) begin
            w_idle_cyc = '0;
            if (r_tmo_bits == TmoW'(TIMEOUT_BITS - 1)) begin
              w_tmo_bits = '0;
              w_byte_idx = 3'd0;
              w_timeout  = 1'b1;
            end else begin
              w_tmo_bits = r_tmo_bits + 1'b1;
            end
          end else begin
            w_idle_cyc = r_idle_cyc + 1'b1;
          end
        end else begin
          w_idle_cyc = '0;
          w_tmo_bits = '0;
        end
      end
      StStart: begin
        if (w_bit_strobe) begin
          w_bit_idx = 4'd0;
          w_state   = w_bit_val ? StIdle : StData;
        end
      end
      StData: begin
        if (w_bit_strobe) begin
          w_shift = {w_bit_val, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == 4'(DATA_BITS - 1)) begin
            w_bit_idx  = 4'd0;
            w_stop_bad = 1'b0;
            w_state    = (PARITY_MODE != PAR_NONE) ? StParity : StStop;
          end else begin
            w_bit_idx = r_bit_idx + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_bit_strobe) begin
          w_par_bit = w_bit_val;
          w_state   = StStop;
        end
      end
      StStop: begin
        if (w_bit_strobe) begin
          w_stop_bad = r_stop_bad | ~w_bit_val;
          if (r_bit_idx == 4'(STOP_BITS - 1)) begin
            w_bit_idx = 4'd0;
            w_frm     = r_stop_bad | ~w_bit_val;
            w_par     = (PARITY_MODE != PAR_NONE) && (r_par_bit != w_par_exp);
            if (w_frm || w_par) begin
              w_frame_err  = w_frm;
              w_parity_err = w_par;
              w_byte_idx   = 3'd0;
              w_idle_cyc   = '0;
              w_state      = w_frm ? StWaitIdle : StIdle;
            end else begin
              for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (r_byte_idx == 3'(i)) w_asm[i*DATA_BITS +: DATA_BITS] = r_shift;
              end
              if (r_byte_idx == 3'(BYTES_PER_WORD - 1)) begin
                w_byte_idx = 3'd0;
                // Held word wins unless the consumer takes it in this very cycle.
                if (r_valid && !word_ready) begin
                  w_overrun = 1'b1;
                end else begin
                  w_word  = w_asm;
                  w_valid = 1'b1;
                end
              end else begin
                w_byte_idx = r_byte_idx + 1'b1;
              end
              w_state = StIdle;
            end
          end else begin
            w_bit_idx = r_bit_idx + 1'b1;
          end
        end
      end
      StWaitIdle: begin
        // A break keeps us here until the line has been high for a whole bit.
        if (!w_rxd_sync) begin
          w_idle_cyc = '0;
        end else if (r_idle_cyc == CntW'(BPS_CNT - 1)) begin
          w_idle_cyc = '0;
          w_state    = StIdle;
        end else begin
          w_idle_cyc = r_idle_cyc + 1'b1;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= StIdle;
      r_bit_idx    <= 4'd0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stop_bad   <= 1'b0;
      r_byte_idx   <= 3'd0;
      r_asm        <= '0;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_idle_cyc   <= '0;
      r_tmo_bits   <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_bit_idx    <= w_bit_idx;
      r_shift      <= w_shift;
      r_par_bit    <= w_par_bit;
      r_stop_bad   <= w_stop_bad;
      r_byte_idx   <= w_byte_idx;
      r_asm        <= w_asm;
      r_word       <= w_word;
      r_valid      <= w_valid;
      r_idle_cyc   <= w_idle_cyc;
      r_tmo_bits   <= w_tmo_bits;
      r_frame_err  <= w_frame_err;
      r_parity_err <= w_parity_err;
      r_overrun    <= w_overrun;
      r_timeout    <= w_timeout;
    end
  end

  assign word_data   = r_word;
  assign word_valid  = r_valid;
  assign rx_busy     = (r_state == StStart) || (r_state == StData) ||
                       (r_state == StParity) || (r_state == StStop);
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
Parametrised UART receiver that deserialises frames with configurable data bits, parity and stop bits. It assembles BYTES_PER_WORD consecutive characters into one output word and presents the word on a valid/ready handshake. Start-bit qualification and 3-sample majority voting give noise tolerance, and the block reports errors per character. It sits directly behind the board RX pin and feeds word-oriented consumers (command decoders, register loaders).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 9600, baud rate; BPS_CNT = CLK_FREQ/UART_BPS, must be >= 16
DATA_BITS, 8, data bits per character, legal range 5..8
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
BYTES_PER_WORD, 2, characters per output word, legal range 1..4
TIMEOUT_BITS, 16, idle bit-periods after which a partial word is discarded

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous reset, active-high
uart_rxd  in  1  serial input, asynchronous to sys_clk, idle high
word_data  out  DATA_BITS*BYTES_PER_WORD  assembled word; first received character in the LSBs
word_valid  out  1  word_data holds an unconsumed word
word_ready  in  1  consumer accepts the word when word_valid and word_ready are both high
rx_busy  out  1  high from start-bit detection until the end-of-frame sample
frame_err  out  1  1-cycle pulse: stop bit sampled low
parity_err  out  1  1-cycle pulse: parity mismatch
overrun  out  1  1-cycle pulse: completed word dropped because the held word was not consumed
timeout_err  out  1  1-cycle pulse: partial word discarded by idle timeout

Behaviour:
- Reset values: all outputs 0; internal synchroniser flops reset to 1 (idle line), so reset release produces no false start.
- Synchronisation: uart_rxd passes through 2 flops. Falling-edge detection and all sampling use the synchronised signal.
- Bit counter: counts 0..BPS_CNT-1 within each bit period. Samples are taken at BPS_CNT/2-1, BPS_CNT/2 and BPS_CNT/2+1; the bit value is the majority of the three, registered at BPS_CNT/2+1. Counter width is clog2(BPS_CNT).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE -> START on a falling edge.
  - START: majority 1 means false start; go to IDLE with no flag. Majority 0 goes to DATA.
  - DATA: sample DATA_BITS bits, LSB first. Then go to PARITY if PARITY_MODE != 0, otherwise STOP.
  - PARITY: compare the sampled bit with the computed even or odd parity.
  - STOP: sample STOP_BITS stop bits.
  - Exit from STOP: any stop bit 0 -> frame_err, then WAIT_IDLE. All stop bits 1 -> IDLE.
  - WAIT_IDLE: return to IDLE once the line has been high for one full bit period. This covers a break condition.
- Character accept: on the final stop-bit sample with no errors, the character is written into slot byte_idx of the assembly register and byte_idx increments.
- Character error: on a frame or parity error the character is discarded, byte_idx resets to 0, the partial word is dropped and the error pulse fires in the same cycle. Parity is evaluated only at the stop sample. If both errors occur in one character, both pulses fire.
- Word completion: when byte_idx reaches BYTES_PER_WORD it wraps to 0 and the word is offered. Latency is 1 cycle: word_valid rises on the cycle after the final stop-bit majority sample.
- Handshake: word_data stays stable while word_valid is high. word_valid clears on the cycle after valid && ready.
- Overrun: if a word completes while word_valid is high and word_ready is low, the new word is dropped, the held word is kept and overrun pulses. If word_ready is high in the completion cycle, the held word is consumed and the new word is loaded, with no overrun.
- Timeout: while 0 < byte_idx < BYTES_PER_WORD and the FSM is in IDLE, an idle counter counts bit periods. On reaching TIMEOUT_BITS: byte_idx resets to 0 and timeout_err pulses. The idle counter clears on any start bit.
- rx_busy is high in START, DATA, PARITY and STOP.
- Reset mid-frame: asynchronous return to IDLE; partial word and held word are cleared; no error pulses.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the FSM state enum;
  - function clog2;
  - localparam computation for BPS_CNT.
- Sub-module uart_rx_sampler contains the 2-flop synchroniser, the falling-edge detector, the bit counter and the 3-sample majority vote. It outputs start_edge, bit_val and bit_strobe. The FSM, assembly and handshake logic stay in uart_rx_word.

Test Plan:
1. Defaults (8N1, 2 chars/word), send 0x34 then 0x12, word_ready held high -> word_data=0x1234; word_valid high for 1 cycle, 1 cycle after the second stop-bit sample; no error pulses.
2. PARITY_MODE=1, send 0xA5 with parity bit 1 (expected 0), then 0x11 and 0x22 -> parity_err pulses once; next word_data=0x2211.
3. 1000-cycle low glitch on uart_rxd (BPS_CNT=5208) -> START aborts; rx_busy returns to 0; no word, no errors. Then send 0x55 and 0xAA -> word_data=0xAA55.
4. Stop bit driven 0 on the second character, then line held low for 3 bit times, then valid 0x01 and 0x02 -> frame_err pulse; no word until line idle; then word_data=0x0201.
5. word_ready held 0; send 0x1111 then 0x2222 -> first word held; overrun pulses on second completion. Raise ready -> word_data=0x1111 consumed; word_valid drops next cycle.
6. Send 0x7E only, idle 20 bit times (TIMEOUT_BITS=16) -> timeout_err after exactly 16 bit periods. Then 0x01 and 0x02 -> word_data=0x0201. Also assert sys_rst mid-character -> all outputs 0 immediately; no pulses after release.
